// File: rtl/rot_cmd_sequencer_if.sv
// Bundle of the command, result and rotator-control signals around the
// rotate command sequencer. The sequencer takes the slave view; the host
// together with the rotator instance takes the master view.
interface rot_cmd_sequencer_if #(
    parameter int WIDTH = 100,
    parameter int AMT_W = 7
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [AMT_W-1:0] cmd_amt;
    logic             cmd_load;
    logic [WIDTH-1:0] cmd_data;
    logic             rot_load;
    logic [1:0]       rot_ena;
    logic [WIDTH-1:0] rot_data;
    logic [WIDTH-1:0] rot_q;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             busy;

    modport master (
        output cmd_valid, cmd_dir, cmd_amt, cmd_load, cmd_data, res_ready, rot_q,
        input  cmd_ready, rot_load, rot_ena, rot_data, res_valid, res_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_amt, cmd_load, cmd_data, res_ready, rot_q,
        output cmd_ready, rot_load, rot_ena, rot_data, res_valid, res_data, busy
    );
endinterface

// File: rtl/rot_cmd_sequencer.sv
// Rotate command sequencer. Accepts a rotate command, optionally loads a new
// word into the external rotator, steps the rotator one bit per cycle in the
// shorter direction, then presents the rotated word until it is taken.
module rot_cmd_sequencer #(
    parameter int WIDTH = 100,
    parameter int AMT_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    rot_cmd_sequencer_if.slave bus
);
    // Largest step count after taking the shorter direction is WIDTH/2.
    localparam int STEP_W = $clog2(WIDTH / 2 + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ROT  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                dir;
    logic [WIDTH-1:0]    data;
    logic [STEP_W-1:0]   cnt;
    logic                accept;
    logic                norm_dir;
    logic [STEP_W-1:0]   norm_steps;

    // Fold the amount into 0..WIDTH-1, then turn anything past half a turn
    // into the complementary rotation the other way. An exact half turn keeps
    // the commanded direction. Result is {direction, steps}.
    function automatic logic [STEP_W:0] normalize(input logic d,
                                                  input logic [AMT_W-1:0] amt);
        int   a;
        int   s;
        logic od;
        a  = int'(amt);
        if (a >= WIDTH) a = a - WIDTH;
        od = d;
        s  = a;
        if (a > WIDTH / 2) begin
            od = ~d;
            s  = WIDTH - a;
        end
        return {od, STEP_W'(s)};
    endfunction

    // Normalized direction/steps of the command currently offered.
    always_comb begin
        {norm_dir, norm_steps} = normalize(bus.cmd_dir, bus.cmd_amt);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode and Moore outputs; cmd_valid/res_ready only steer
    // the next state, never an output directly.
    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.rot_load  = 1'b0;
        bus.rot_ena   = 2'b00;
        bus.res_valid = 1'b0;
        bus.busy      = 1'b1;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.cmd_valid) begin
                    accept = 1'b1;
                    if (bus.cmd_load)          state_next = LOAD;
                    else if (norm_steps != '0) state_next = ROT;
                    else                       state_next = DONE;
                end
            end
            LOAD: begin
                bus.rot_load = 1'b1;
                state_next   = (cnt != '0) ? ROT : DONE;
            end
            ROT: begin
                bus.rot_ena = dir ? 2'b10 : 2'b01;
                // cnt==0 cannot occur here; treat it as finished for safety.
                if (cnt <= STEP_W'(1)) state_next = DONE;
            end
            DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Command latch on accept and step counter countdown while rotating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir  <= 1'b0;
            data <= '0;
            cnt  <= '0;
        end else if (accept) begin
            dir  <= norm_dir;
            data <= bus.cmd_data;
            cnt  <= norm_steps;
        end else if (state == ROT && cnt != '0) begin
            cnt  <= cnt - STEP_W'(1);
        end
    end

    assign bus.rot_data = data;
    assign bus.res_data = bus.rot_q;
endmodule

// File: tb/tb_rot_cmd_sequencer.sv
// Bench for rot_cmd_sequencer: a behavioural rotator closes the loop, and
// expected results come from rotating the start word by (amt mod WIDTH) in
// the commanded direction with plain shifts.
module tb_rot_cmd_sequencer;
    localparam int WIDTH = 100;
    localparam int AMT_W = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;

    rot_cmd_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    rot_cmd_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Rotator model: load has priority, otherwise one-bit step per ena.
    logic [WIDTH-1:0] q = '0;
    always @(posedge clk) begin
        if (bus.rot_load)              q <= bus.rot_data;
        else if (bus.rot_ena == 2'b01) q <= {q[0], q[WIDTH-1:1]};
        else if (bus.rot_ena == 2'b10) q <= {q[WIDTH-2:0], q[WIDTH-1]};
    end
    assign bus.rot_q = q;

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] exp_res;
    int               exp_steps;
    logic             exp_left;
    logic             exp_load;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_rotate(input logic [WIDTH-1:0] w,
                                                    input logic left, input int k);
        if (k == 0) return w;
        if (left) return (w << k) | (w >> (WIDTH - k));
        return (w >> k) | (w << (WIDTH - k));
    endfunction

    // Drive a command (at a negedge) and work out what it must produce.
    task automatic start_cmd(input logic d, input logic [AMT_W-1:0] amt,
                             input logic ld, input logic [WIDTH-1:0] w);
        int k;
        logic [WIDTH-1:0] base;
        chk_int("cmd_ready_idle", int'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = d;
        bus.cmd_amt   = amt;
        bus.cmd_load  = ld;
        bus.cmd_data  = w;
        base      = ld ? w : q;
        k         = int'(amt) % WIDTH;
        exp_res   = ref_rotate(base, d, k);
        exp_load  = ld;
        if (2 * k > WIDTH) begin
            exp_steps = WIDTH - k;
            exp_left  = ~d;
        end else begin
            exp_steps = k;
            exp_left  = d;
        end
    endtask

    // Accept edge, then watch the rotator controls until res_valid.
    task automatic wait_result(input string tag);
        int n_load = 0, n_left = 0, n_right = 0, lat = 0;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk_int({tag, "_busy"}, int'(bus.busy), 1);
        for (int c = 1; c <= 70; c++) begin
            if (c > 1) @(negedge clk);
            if (bus.res_valid) begin
                lat = c;
                break;
            end
            if (bus.rot_load) n_load++;
            if (bus.rot_ena == 2'b10) n_left++;
            if (bus.rot_ena == 2'b01) n_right++;
        end
        chk_int({tag, "_latency"}, lat, exp_steps + 1 + int'(exp_load));
        chk_int({tag, "_loads"}, n_load, int'(exp_load));
        chk_int({tag, "_ena_left"}, n_left, exp_left ? exp_steps : 0);
        chk_int({tag, "_ena_right"}, n_right, exp_left ? 0 : exp_steps);
        chk({tag, "_res_data"}, bus.res_data, exp_res);
    endtask

    // Keep the result waiting for a while, then take it.
    task automatic finish_result(input string tag, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk_int({tag, "_hold_valid"}, int'(bus.res_valid), 1);
            chk({tag, "_hold_data"}, bus.res_data, exp_res);
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk_int({tag, "_after_valid"}, int'(bus.res_valid), 0);
        chk_int({tag, "_after_ready"}, int'(bus.cmd_ready), 1);
    endtask

    initial begin
        logic [127:0] r;
        bus.cmd_valid = 1'b0;
        bus.cmd_dir   = 1'b0;
        bus.cmd_amt   = '0;
        bus.cmd_load  = 1'b0;
        bus.cmd_data  = '0;
        bus.res_ready = 1'b0;

        // Reset asserted between clock edges takes effect at once.
        #1 rst = 1'b1;
        #1;
        chk_int("rst_cmd_ready", int'(bus.cmd_ready), 1);
        chk_int("rst_rot_load", int'(bus.rot_load), 0);
        chk_int("rst_rot_ena", int'(bus.rot_ena), 0);
        chk_int("rst_res_valid", int'(bus.res_valid), 0);
        chk_int("rst_busy", int'(bus.busy), 0);
        chk("rst_rot_data", bus.rot_data, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Load 888888888 and rotate left by 3.
        start_cmd(1'b1, 7'd3, 1'b1, 100'd888888888);
        wait_result("ld_left3");
        chk("ld_left3_const", bus.res_data, 100'd7111111104);
        finish_result("ld_left3", 2);

        // amt=0 with load: preload 1, no stepping.
        start_cmd(1'b0, 7'd0, 1'b1, 100'd1);
        wait_result("amt0_load");
        finish_result("amt0_load", 0);

        // Right 70 from q=1 is done as 30 left steps.
        start_cmd(1'b0, 7'd70, 1'b0, '0);
        wait_result("right70");
        chk("right70_const", bus.res_data, 100'd1 << 30);
        finish_result("right70", 1);

        // amt=105 folds to 5.
        start_cmd(1'b1, 7'd105, 1'b0, '0);
        wait_result("amt105");
        chk("amt105_const", bus.res_data, 100'd1 << 35);
        finish_result("amt105", 0);

        // Half turn right keeps the commanded direction.
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        start_cmd(1'b0, 7'd50, 1'b1, r[WIDTH-1:0]);
        wait_result("half_right");
        finish_result("half_right", 0);

        // Result held 10 cycles with another command pending.
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        start_cmd(1'b1, 7'd10, 1'b1, r[WIDTH-1:0]);
        wait_result("hold_a");
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = 1'b0;
        bus.cmd_amt   = 7'd60;
        bus.cmd_load  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_int("hold_valid", int'(bus.res_valid), 1);
            chk("hold_data", bus.res_data, exp_res);
            chk_int("hold_cmd_ready", int'(bus.cmd_ready), 0);
            chk_int("hold_ena", int'(bus.rot_ena), 0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk_int("hold_idle_ready", int'(bus.cmd_ready), 1);
        chk_int("hold_idle_valid", int'(bus.res_valid), 0);
        start_cmd(1'b0, 7'd60, 1'b0, bus.cmd_data);
        wait_result("hold_b");
        finish_result("hold_b", 0);

        // Reset in the middle of a 20-step rotation.
        start_cmd(1'b0, 7'd20, 1'b0, '0);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 7; i++) @(negedge clk);
        chk_int("midrot_ena_before", int'(bus.rot_ena), 1);
        #2 rst = 1'b1;
        #1;
        chk_int("midrot_ena", int'(bus.rot_ena), 0);
        chk_int("midrot_load", int'(bus.rot_load), 0);
        chk_int("midrot_busy", int'(bus.busy), 0);
        chk_int("midrot_ready", int'(bus.cmd_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_int("midrot_no_valid", int'(bus.res_valid), 0);
        end
        start_cmd(1'b1, 7'd9, 1'b0, '0);
        wait_result("after_rst");
        finish_result("after_rst", 0);

        // Randomized commands.
        for (int n = 0; n < 20; n++) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            start_cmd(1'($urandom_range(0, 1)), AMT_W'($urandom_range(0, 127)),
                      1'($urandom_range(0, 1)), r[WIDTH-1:0]);
            wait_result("rand");
            finish_result("rand", int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
